// File: rtl/grant_capture_fifo_pkg.sv
// Shared types and helpers for the priority_mux / grant_capture_fifo pair.
// The entry struct gains a timestamp field when GRANT_CAPTURE_TIMESTAMP_EN is defined.
package priority_mux_pkg;

    localparam int N_SIGNAL_WIDTH_DEF = 8;
    localparam int N_SIGNALS_DEF      = 8;
    localparam int DEPTH_DEF          = 8;
    localparam int TS_WIDTH_DEF       = 16;

    typedef logic [$clog2(N_SIGNALS_DEF)-1:0] src_idx_t;

    typedef struct packed {
        logic [N_SIGNAL_WIDTH_DEF-1:0] data;
        src_idx_t                      src;
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
        logic [TS_WIDTH_DEF-1:0]       ts;
`endif
    } entry_t;

    function automatic bit depth_ok(input int unsigned d);
        return (d >= 32'd2) && ((d & (d - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/grant_capture_fifo_onehot.sv
// Converts a grant vector to the index of its lowest set bit and reports
// whether any bit, or more than one bit, is set. Purely combinational.
module onehot_to_index #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set,
    output logic             multi_set
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        any_set   = |vec;
        multi_set = |(vec & (vec - N'(1)));
    end

endmodule

// File: rtl/grant_capture_fifo.sv
// Captures each new grant from priority_mux into a first-word-fall-through FIFO.
// Optional GRANT_CAPTURE_TIMESTAMP_EN adds a per-entry cycle timestamp and out_ts.
module grant_capture_fifo
    import priority_mux_pkg::*;
#(
    parameter int N_SIGNAL_WIDTH = N_SIGNAL_WIDTH_DEF,
    parameter int N_SIGNALS      = N_SIGNALS_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int TS_WIDTH       = TS_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SIGNAL_WIDTH-1:0]    signal_in,
    input  logic [N_SIGNALS-1:0]         signal_ack_in,
    output logic [N_SIGNAL_WIDTH-1:0]    out_data,
    output logic [$clog2(N_SIGNALS)-1:0] out_src,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         onehot_err,
    input  logic                         clr_flags
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]          out_ts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(N_SIGNALS);

    if (!depth_ok(DEPTH)) begin : g_depth_check
        $error("grant_capture_fifo: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [N_SIGNAL_WIDTH-1:0] data;
        logic [SRC_W-1:0]          src;
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
        logic [TS_WIDTH-1:0]       ts;
`endif
    } fifo_entry_t;

    fifo_entry_t          mem_q [DEPTH];
    fifo_entry_t          mem_d [DEPTH];
    fifo_entry_t          new_entry_s;
    fifo_entry_t          head_s;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [N_SIGNALS-1:0] ack_q;
    logic                 overflow_q, overflow_d, onehot_err_q, onehot_err_d;
    logic [SRC_W-1:0]     grant_idx_s;
    logic                 grant_any_s, grant_multi_s;
    logic                 full_s, empty_s, pop_s, push_req_s, push_ok_s;
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]  ts_q;
`endif

    onehot_to_index #(
        .N     (N_SIGNALS),
        .IDX_W (SRC_W)
    ) u_onehot_to_index (
        .vec       (signal_ack_in),
        .idx       (grant_idx_s),
        .any_set   (grant_any_s),
        .multi_set (grant_multi_s)
    );

    // Push/pop decisions and next-state for storage, pointers, count and sticky flags.
    always_comb begin
        full_s     = (count_q == CNT_W'(DEPTH));
        empty_s    = (count_q == {CNT_W{1'b0}});
        pop_s      = !empty_s && out_ready;
        push_req_s = grant_any_s && (signal_ack_in != ack_q);
        push_ok_s  = push_req_s && (!full_s || pop_s);

        new_entry_s.data = signal_in;
        new_entry_s.src  = grant_idx_s;
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
        new_entry_s.ts   = ts_q;
`endif

        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = new_entry_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new error in the clearing cycle must survive the clear.
        overflow_d   = (clr_flags ? 1'b0 : overflow_q)   | (push_req_s && !push_ok_s);
        onehot_err_d = (clr_flags ? 1'b0 : onehot_err_q) | (push_req_s && grant_multi_s);
    end

    // State registers; reset also wipes storage so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{default: 1'b0};
            end
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            ack_q        <= {N_SIGNALS{1'b0}};
            overflow_q   <= 1'b0;
            onehot_err_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ack_q        <= signal_ack_in;
            overflow_q   <= overflow_d;
            onehot_err_q <= onehot_err_d;
        end
    end

`ifdef GRANT_CAPTURE_TIMESTAMP_EN
    // Free-running capture timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= {TS_WIDTH{1'b0}};
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end
    assign out_ts = head_s.ts;
`endif

    assign head_s     = mem_q[rd_ptr_q];
    assign out_data   = head_s.data;
    assign out_src    = head_s.src;
    assign out_valid  = !empty_s;
    assign count      = count_q;
    assign full       = full_s;
    assign empty      = empty_s;
    assign overflow   = overflow_q;
    assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_grant_capture_fifo.sv
// Directed self-checking bench for grant_capture_fifo (default 8x8, DEPTH 8).
// Exercises the timestamp path when GRANT_CAPTURE_TIMESTAMP_EN is defined.
module tb_grant_capture_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] signal_in;
    logic [7:0] signal_ack_in;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       onehot_err;
    logic       clr_flags;
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    int checks = 0;
    int errors = 0;

    grant_capture_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .signal_in     (signal_in),
        .signal_ack_in (signal_ack_in),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .onehot_err    (onehot_err),
        .clr_flags     (clr_flags)
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
        ,
        .out_ts        (out_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; one call spans one rising edge.
    task automatic cap(input logic [7:0] ack, input logic [7:0] data);
        signal_ack_in = ack;
        signal_in     = data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; signal_in = 8'd0; signal_ack_in = 8'd0; out_ready = 1'b0; clr_flags = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, empty, full, count, out_data, out_src, overflow, onehot_err} !==
            {1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v=%0b e=%0b f=%0b c=%0d d=%0h s=%0d ov=%0b oh=%0b exp v=0 e=1 f=0 c=0 d=0 s=0 ov=0 oh=0",
                     out_valid, empty, full, count, out_data, out_src, overflow, onehot_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_ack();
        signal_ack_in = 8'h04; signal_in = 8'd40;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_pre_edge_valid got %0b exp 0", out_valid); end
        @(negedge clk);
        checks++;
        if ({out_valid, count, out_data, out_src} !== {1'b1, 4'd1, 8'd40, 3'd2}) begin
            errors++;
            $display("FAIL hold_first_capture got v=%0b c=%0d d=%0d s=%0d exp v=1 c=1 d=40 s=2", out_valid, count, out_data, out_src);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL hold_single_capture got count=%0d exp 1", count); end
        signal_ack_in = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({empty, count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL hold_pop got e=%0b c=%0d exp e=1 c=0", empty, count); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({empty, count, overflow} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL empty_ready_noop got e=%0b c=%0d ov=%0b exp e=1 c=0 ov=0", empty, count, overflow);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_d [3];
        logic [2:0] exp_s [3];
        exp_d = '{8'd10, 8'd20, 8'd30};
        exp_s = '{3'd0, 3'd7, 3'd0};
        cap(8'h01, 8'd10); cap(8'h80, 8'd20); cap(8'h00, 8'd0); cap(8'h01, 8'd30); cap(8'h00, 8'd0);
        checks++;
        if (count !== 4'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", count); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_valid, out_data, out_src} !== {1'b1, exp_d[k], exp_s[k]}) begin
                errors++;
                $display("FAIL seq_order[%0d] got v=%0b d=%0d s=%0d exp v=1 d=%0d s=%0d", k, out_valid, out_data, out_src, exp_d[k], exp_s[k]);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL seq_empty got %0b exp 1", empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] ed;
        logic [2:0] es;
        for (int i = 0; i < 8; i++) begin
            cap((i % 2 == 1) ? 8'h02 : 8'h01, 8'(100 + i));
        end
        checks++;
        if ({count, full, overflow} !== {4'd8, 1'b1, 1'b0}) begin
            errors++; $display("FAIL fill_8 got c=%0d f=%0b ov=%0b exp c=8 f=1 ov=0", count, full, overflow);
        end
        cap(8'h04, 8'd200);
        checks++;
        if ({count, full, overflow, out_data, out_src} !== {4'd8, 1'b1, 1'b1, 8'd100, 3'd0}) begin
            errors++;
            $display("FAIL overflow_drop got c=%0d f=%0b ov=%0b d=%0d s=%0d exp c=8 f=1 ov=1 d=100 s=0", count, full, overflow, out_data, out_src);
        end
        out_ready = 1'b1;
        cap(8'h08, 8'd201);
        out_ready = 1'b0;
        cap(8'h00, 8'd0);
        checks++;
        if ({count, overflow, out_data, out_src} !== {4'd8, 1'b1, 8'd101, 3'd1}) begin
            errors++;
            $display("FAIL full_push_pop got c=%0d ov=%0b d=%0d s=%0d exp c=8 ov=1 d=101 s=1", count, overflow, out_data, out_src);
        end
        for (int k = 0; k < 8; k++) begin
            ed = (k < 7) ? 8'(101 + k) : 8'd201;
            es = (k < 7) ? 3'((k + 1) % 2) : 3'd3;
            checks++;
            if ({out_data, out_src} !== {ed, es}) begin
                errors++; $display("FAIL drain[%0d] got d=%0d s=%0d exp d=%0d s=%0d", k, out_data, out_src, ed, es);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if ({empty, overflow} !== {1'b1, 1'b1}) begin
            errors++; $display("FAIL overflow_sticky got e=%0b ov=%0b exp e=1 ov=1", empty, overflow);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %0b exp 0", overflow); end
    endtask

    task automatic test_onehot_err();
        cap(8'h30, 8'd55);
        checks++;
        if ({out_data, out_src, onehot_err} !== {8'd55, 3'd4, 1'b1}) begin
            errors++; $display("FAIL multihot_capture got d=%0d s=%0d oh=%0b exp d=55 s=4 oh=1", out_data, out_src, onehot_err);
        end
        cap(8'h00, 8'd0);
        clr_flags = 1'b1;
        cap(8'h0C, 8'd66);
        clr_flags = 1'b0;
        checks++;
        if ({onehot_err, count} !== {1'b1, 4'd2}) begin
            errors++; $display("FAIL clr_vs_new_error got oh=%0b c=%0d exp oh=1 c=2", onehot_err, count);
        end
        cap(8'h00, 8'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checks++;
        if (onehot_err !== 1'b0) begin errors++; $display("FAIL onehot_clear got %0b exp 0", onehot_err); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_data, out_src} !== {8'd66, 3'd2}) begin
            errors++; $display("FAIL multihot_second got d=%0d s=%0d exp d=66 s=2", out_data, out_src);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            cap((i % 2 == 1) ? 8'h02 : 8'h01, 8'(50 + i));
        end
        cap(8'h00, 8'd0);
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d exp 5", count); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, empty, full, count, out_data, out_src} !== {1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset got v=%0b e=%0b f=%0b c=%0d d=%0h s=%0d exp v=0 e=1 f=0 c=0 d=0 s=0",
                     out_valid, empty, full, count, out_data, out_src);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cap(8'h40, 8'd77);
        cap(8'h00, 8'd0);
        checks++;
        if ({out_valid, count, out_data, out_src} !== {1'b1, 4'd1, 8'd77, 3'd6}) begin
            errors++; $display("FAIL post_reset_capture got v=%0b c=%0d d=%0d s=%0d exp v=1 c=1 d=77 s=6", out_valid, count, out_data, out_src);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef GRANT_CAPTURE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [15:0] t0;
        logic [15:0] diff;
        cap(8'h01, 8'd1);
        signal_ack_in = 8'h00;
        t0 = out_ts;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        cap(8'h02, 8'd2);
        signal_ack_in = 8'h00;
        diff = out_ts - t0;
        checks++;
        if (diff !== 16'd7) begin errors++; $display("FAIL ts_delta got %0d exp 7", diff); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hold_ack();
        test_sequence();
        test_overflow();
        test_onehot_err();
        test_async_reset();
`ifdef GRANT_CAPTURE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
